// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, forwarding selects, shadow-stage
// records and the hazard FSM state type.
package mips_pkg;

  localparam logic [5:0] ALUop   = 6'd0;
  localparam logic [5:0] Jop     = 6'd2;
  localparam logic [5:0] JALop   = 6'd3;
  localparam logic [5:0] ADD_IMM = 6'd8;
  localparam logic [5:0] LW      = 6'd35;
  localparam logic [5:0] SW      = 6'd43;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       reads_rs;
    logic       reads_rt;
    logic       is_load;
  } idex_t;

  typedef struct packed {
    logic [4:0] dest;
    logic       is_load;
  } wbk_t;

  typedef enum logic {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } state_e;

  // A load still in EX/MEM has no data yet, so it may only forward from MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic       rd_en,
                                         input logic [4:0] src,
                                         input wbk_t       exm,
                                         input wbk_t       mwb);
    logic [1:0] sel;
    sel = FWD_REG;
    if (rd_en && exm.dest != 5'd0 && exm.dest == src && !exm.is_load) begin
      sel = FWD_MEM;
    end else if (rd_en && mwb.dest != 5'd0 && mwb.dest == src) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the ID-stage instruction into the register-usage
// record tracked by the hazard controller.
module instr_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir_i,
  output idex_t       dec_o,
  output logic        is_jump_o
);

  logic unused_imm;
  assign unused_imm = ^ir_i[10:0];

  always_comb begin
    dec_o     = '0;
    is_jump_o = 1'b0;
    dec_o.rs  = ir_i[25:21];
    dec_o.rt  = ir_i[20:16];
    case (ir_i[31:26])
      ALUop: begin
        dec_o.dest     = ir_i[15:11];
        dec_o.reads_rs = 1'b1;
        dec_o.reads_rt = 1'b1;
      end
      LW: begin
        dec_o.dest     = ir_i[20:16];
        dec_o.reads_rs = 1'b1;
        dec_o.is_load  = 1'b1;
      end
      ADD_IMM: begin
        dec_o.dest     = ir_i[20:16];
        dec_o.reads_rs = 1'b1;
      end
      SW: begin
        dec_o.reads_rs = 1'b1;
        dec_o.reads_rt = 1'b1;
      end
      Jop: begin
        is_jump_o = 1'b1;
      end
      JALop: begin
        dec_o.dest = 5'd31;
        is_jump_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and jump-flush controller driven by a
// shadow copy of the ID/EX, EX/MEM and MEM/WB register-usage fields.
module fwd_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ifid_ir,
  input  logic             hold,
  output logic [1:0]       fa,
  output logic [1:0]       fb,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  idex_t            dec;
  logic             is_jump;
  logic             hazard;
  idex_t            idex_q, idex_d;
  wbk_t             exmem_q, memwb_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  instr_decode u_decode (
    .ir_i      (ifid_ir),
    .dec_o     (dec),
    .is_jump_o (is_jump)
  );

  always_comb begin
    hazard = idex_q.is_load && (idex_q.dest != 5'd0) &&
             ((dec.reads_rs && dec.rs == idex_q.dest) ||
              (dec.reads_rt && dec.rt == idex_q.dest));
  end

  always_comb begin
    state_d = state_q;
    idex_d  = dec;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    if (!hold) begin
      flush = is_jump;
      if (state_q == RUN) begin
        if (hazard) begin
          stall   = 1'b1;
          state_d = LDSTALL;
        end
      end else begin
        state_d = RUN;
      end
      // The stalled instruction stays in IF/ID; EX receives a bubble instead.
      if (stall) begin
        idex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (!hold) begin
      idex_q  <= idex_d;
      exmem_q <= wbk_t'{dest: idex_q.dest, is_load: idex_q.is_load};
      memwb_q <= exmem_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fa          = fwd_sel(idex_q.reads_rs, idex_q.rs, exmem_q, memwb_q);
  assign fb          = fwd_sel(idex_q.reads_rt, idex_q.rt, exmem_q, memwb_q);
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: the bench plays the IF/ID register and
// checks selects, stall, flush and the stall counter every cycle.
module tb_fwd_hazard_ctrl;

  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             hold;
  logic [31:0]      ifid_ir;
  logic [1:0]       fa, fb;
  logic             stall, flush;
  logic [CNT_W-1:0] stall_count;

  typedef struct packed {
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  int               n_pass  = 0;
  int               n_total = 0;
  logic [CNT_W-1:0] exp_cnt;

  fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .ifid_ir     (ifid_ir),
    .hold        (hold),
    .fa          (fa),
    .fb          (fb),
    .stall       (stall),
    .flush       (flush),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
  endtask

  // One pipeline cycle: drive ID instruction, queue the expectation, compare mid-cycle.
  task automatic cyc(input string name, input logic [31:0] ir, input logic h,
                     input logic [1:0] efa, input logic [1:0] efb,
                     input logic est, input logic efl);
    exp_t e;
    ifid_ir = ir;
    hold    = h;
    exp_q.push_back('{efa, efb, est, efl, exp_cnt});
    @(negedge clock);
    e = exp_q.pop_front();
    $display("step %s ir=%h hold=%b fa=%b fb=%b stall=%b flush=%b cnt=%0d",
             name, ir, h, fa, fb, stall, flush, stall_count);
    chk({name, ".fa"},    8'(fa),          8'(e.fa));
    chk({name, ".fb"},    8'(fb),          8'(e.fb));
    chk({name, ".stall"}, 8'(stall),       8'(e.stall));
    chk({name, ".flush"}, 8'(flush),       8'(e.flush));
    chk({name, ".cnt"},   8'(stall_count), 8'(e.cnt));
    if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc("drain", NOP, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    hold    = 1'b0;
    ifid_ir = NOP;
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  logic [31:0] add3, add3b, sub435, sub453, sub433, lw2, add425, add0, sub400, sub436;
  logic [31:0] jmp, jal, add5_31;

  initial begin
    add3    = rtype(5'd1, 5'd2, 5'd3);
    add3b   = rtype(5'd7, 5'd8, 5'd3);
    sub435  = rtype(5'd3, 5'd5, 5'd4);
    sub453  = rtype(5'd5, 5'd3, 5'd4);
    sub433  = rtype(5'd3, 5'd3, 5'd4);
    sub436  = rtype(5'd3, 5'd6, 5'd4);
    lw2     = itype(6'd35, 5'd1, 5'd2);
    add425  = rtype(5'd2, 5'd5, 5'd4);
    add0    = rtype(5'd1, 5'd2, 5'd0);
    sub400  = rtype(5'd0, 5'd0, 5'd4);
    jmp     = {6'd2, 26'h0000123};
    jal     = {6'd3, 26'h0000040};
    add5_31 = rtype(5'd31, 5'd0, 5'd5);

    do_reset();
    cyc("reset_nop", NOP, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // EX/MEM forwarding on rs, then on rt
    cyc("exm_a.add",  add3,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("exm_a.sub",  sub435, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("exm_a.ex",   NOP,    1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    drain(3);
    cyc("exm_b.add",  add3,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("exm_b.sub",  sub453, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("exm_b.ex",   NOP,    1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
    drain(3);

    // MEM/WB forwarding on both operands
    cyc("wb.add",     add3,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("wb.nop",     NOP,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("wb.sub",     sub433, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("wb.ex",      NOP,    1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    drain(3);

    // Load-use: one stall cycle, IF/ID held, then MEM/WB forward
    cyc("lu.lw",      lw2,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("lu.stall",   add425, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    cyc("lu.bubble",  add425, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("lu.ex",      NOP,    1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    drain(3);

    // Same pair with hold across the hazard
    cyc("luh.lw",     lw2,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("luh.hold", add425, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("luh.stall",  add425, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    cyc("luh.bubble", add425, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("luh.ex",     NOP,    1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    drain(3);

    // Load with one instruction between: no stall, MEM/WB forward
    cyc("lg.lw",      lw2,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("lg.nop",     NOP,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("lg.add",     add425, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("lg.ex",      NOP,    1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    drain(3);

    // Reset mid-flight discards the in-flight producer and the counter
    cyc("rst.add",    add3,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    do_reset();
    cyc("rst.sub",    sub435, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("rst.ex",     NOP,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    drain(2);

    // $0 is never forwarded
    cyc("r0.add",     add0,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("r0.sub",     sub400, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("r0.ex",      NOP,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    drain(3);

    // Two producers of $3: the newer one in EX/MEM wins
    cyc("nw.add_a",   add3,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("nw.add_b",   add3b,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("nw.sub",     sub436, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("nw.ex",      NOP,    1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    drain(3);

    // Jumps flush; held jump does not; JAL result forwards from $31
    cyc("j.hold",     jmp,    1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("j.flush",    jmp,    1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc("j.after",    NOP,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("jal.flush",  jal,    1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc("jal.add",    add5_31, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("jal.ex",     NOP,    1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    drain(3);

    // Repeated load-use pairs drive the counter into saturation
    for (int k = 0; k < 9; k++) begin
      cyc("sat.lw",     lw2,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      cyc("sat.stall",  add425, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      cyc("sat.bubble", add425, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      cyc("sat.ex",     NOP,    1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    end
    cyc("sat.final",  NOP,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage MIPS pipeline. Keeps a shadow copy of the destination/source register fields and opcode class for ID/EX, EX/MEM and MEM/WB. From that copy it produces the ALU-operand forwarding selects `fa`/`fb` consumed by the EX-stage input muxes, a one-cycle load-use stall, and a jump squash of IF/ID. It also counts stall cycles for performance monitoring.

## Interface
- `CNT_W`, 16, width of the stall-cycle counter
- `clock`  in  1  pipeline clock, rising edge
- `reset`  in  1  synchronous, active-high
- `ifid_ir`  in  32  instruction currently held in IF/ID (decode stage)
- `hold`  in  1  external freeze (memory not ready); all internal state frozen
- `fa`  out  2  EX operand A select: 00 register file (IDEXA), 01 MEMWBValue, 10 EXMEMALUOut
- `fb`  out  2  EX operand B select, same encoding as `fa`
- `stall`  out  1  hold PC and IF/ID; insert bubble into ID/EX
- `flush`  out  1  replace IF/ID with NOP on next edge
- `stall_count`  out  `CNT_W`  saturating count of load-use stall cycles

## Operation
- Decode of `ifid_ir` (opcode [31:26]):
  - ALUop (0): dest=rd[15:11]; reads rs and rt.
  - LW (35): dest=rt; reads rs.
  - ADD_IMM (8): dest=rt; reads rs.
  - SW (43): no dest; reads rs (A) and rt (B).
  - Jop (2): no dest, no reads.
  - JALop (3): dest=31, no reads.
  - Any other opcode: no dest, no reads.
- Dest 0 means "no write"; $0 is never forwarded.
- Shadow stages:
  - `id_ex` holds {dest, rs, rt, reads_rs, reads_rt, is_load}.
  - `ex_mem` and `mem_wb` hold {dest, is_load}.
  - On each edge with `hold`=0: `mem_wb`←`ex_mem`, `ex_mem`←`id_ex`, `id_ex`←decode(`ifid_ir`), or a bubble (all zero) when `stall`=1.
- Forwarding for operand A; `fb` uses the identical rule on rt/reads_rt:
  - `fa`=10 if `reads_rs` and `ex_mem.dest`≠0 and `ex_mem.dest`==rs and !`ex_mem.is_load`.
  - Otherwise `fa`=01 if `reads_rs` and `mem_wb.dest`≠0 and `mem_wb.dest`==rs.
  - Otherwise `fa`=00.
  - When EX/MEM and MEM/WB both match, EX/MEM (newest) wins.
- Load-use hazard: `id_ex.is_load` and `id_ex.dest`≠0 and the decoded instruction reads that register via rs or rt. This raises `stall`.
- FSM, states RUN and LDSTALL, reset to RUN:
  - RUN→LDSTALL on a hazard with `hold`=0.
  - LDSTALL→RUN unconditionally on the next non-held edge. The bubble has removed the hazard.
  - `stall`=1 only in the hazard cycle, exactly one cycle per load-use pair.
- `flush`=1 when the decoded opcode is Jop or JALop and `hold`=0. A jump has no sources, so `flush` and `stall` are never simultaneously 1.
- `hold`=1 behaviour:
  - `stall`=0 and `flush`=0.
  - Shadows, FSM and counter are unchanged.
  - `fa`/`fb` still reflect the frozen state.
- `stall_count` increments on each edge where `stall`=1. It saturates at 2^CNT_W−1.

## Timing
- Reset values:
  - All shadows zero.
  - FSM=RUN.
  - `stall_count`=0.
  - Hence `fa`=`fb`=00 and `stall`=`flush`=0 in the cycle after reset.
- `reset` mid-operation clears in-flight shadow state. No forwarding occurs from pre-reset instructions.
- `fa`/`fb` are combinational from registered shadow state only, with no input-to-output path. They are valid for the whole cycle the instruction is in EX.
- `stall`/`flush` are combinational from `ifid_ir`, `hold` and `id_ex`. They take effect on the same edge.
- Latency:
  - Instruction in ID at cycle n is in EX (selects valid) at n+1, or n+2 if stalled.
  - Its result is forwardable with 10 at n+2 and with 01 at n+3.

## Structure
- Shared package `mips_pkg`:
  - opcode constants LW, SW, ADD_IMM, ALUop, Jop, JALop;
  - forwarding select localparams FWD_REG/FWD_WB/FWD_MEM (00/01/10);
  - shadow-stage struct typedef;
  - FSM state enum.
- One sub-module is natural: `instr_decode`, a combinational decoder for the ID-stage instruction that yields dest, rs, rt, reads_rs, reads_rt and is_load.

## Test plan
- Reset held 2 cycles, then `ifid_ir`=NOP → `fa`=`fb`=00, `stall`=`flush`=0, `stall_count`=0.
- `add $3,$1,$2` then `sub $4,$3,$5` → with sub in EX, `fa`=10, `fb`=00. With `sub $4,$5,$3` instead → `fa`=00, `fb`=10.
- `add $3,$1,$2`; NOP; `sub $4,$3,$3` → `fa`=01, `fb`=01.
- `lw $2,0($1)`; `add $4,$2,$5` → `stall`=1 for exactly one cycle while add is in ID. Next EX cycle of add: `fa`=01. `stall_count`=1. Same pair with `hold`=1 asserted for 3 cycles at the hazard → `stall`=0 during hold, then one stall cycle, count=1.
- `add $0,$1,$2`; `sub $4,$0,$0` → `fa`=`fb`=00. `add $3,..`; `add $3,..` (new); `sub $4,$3,$6` → `fa`=10, newest wins.
- `ifid_ir`=J target → `flush`=1 for one cycle. JAL → `flush`=1. A following `add $5,$31,$0` two cycles later → `fa`=10. With `stall_count` preset near all-ones via repeated load-use pairs → count saturates, no wrap.
